// File: rtl/sr_latch_driver_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sr_latch_driver_pkg
//  Purpose  : Shared state encodings, command codes and width helpers for the
//             sr_latch_driver block and anything that talks to it.
//  Contents : state_t (ST_IDLE/ST_PULSE/ST_SETTLE/ST_CHECK), cmd_t
//             (CMD_SET/CMD_CLR), cnt_width(), retry_width()
//  Revision : 1.0 - initial release
// ============================================================================
package sr_latch_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PULSE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_CHECK  = 2'd3
  } state_t;

  typedef enum logic {
    CMD_SET = 1'b0,
    CMD_CLR = 1'b1
  } cmd_t;

  // Width of a down-counter that must hold max(p, s); never narrower than 1.
  function automatic int cnt_width(input int p, input int s);
    int m;
    m = (p > s) ? p : s;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

  // Width of a counter that must hold 0..n; never narrower than 1.
  function automatic int retry_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sr_latch_driver_timer.sv
`default_nettype none
// ============================================================================
//  Module   : sr_pulse_timer
//  Purpose  : Loadable down-counter that times the pulse and settle phases.
//             Counts down to zero and holds there (no wrap).
//  Ports    : clk      - rising-edge clock
//             rst      - synchronous active-high reset (value -> 0)
//             load     - load load_val at the next edge (wins over counting)
//             load_val - value to load
//             value    - current count
//             zero     - high while value == 0
//  Revision : 1.0 - initial release
// ============================================================================
module sr_pulse_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] value,
  output logic             zero
);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (value != '0) begin
      value <= value - WIDTH'(1);
    end
  end

  assign zero = (value == '0);

endmodule
`default_nettype wire

// File: rtl/sr_latch_driver.sv
`default_nettype none
// ============================================================================
//  Module   : sr_latch_driver
//  Purpose  : Clocked command driver for the s/r inputs of an SR latch.
//             Turns set/clear requests into timed, mutually exclusive S or R
//             pulses followed by a settle gap. S=R=1 is never driven.
//  Option   : `define SR_LATCH_DRIVER_VERIFY_EN to add a readback CHECK state
//             with retries and a sticky err flag. Without it, q_fb, qn_fb
//             and err_clr are ignored and err is tied low.
//  Ports    : clk, rst           - clock, synchronous active-high reset
//             set_req, clr_req   - requests, sampled only while idle
//                                  (clr_req wins when both are high)
//             err_clr            - clears sticky err
//             q_fb, qn_fb        - latch readback
//             s, r               - latch drive (registered)
//             busy, done, err    - status (registered)
//  Revision : 1.0 - initial release
// ============================================================================
module sr_latch_driver
  import sr_latch_driver_pkg::*;
#(
  parameter int PULSE_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 1,
  parameter int MAX_RETRY     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic set_req,
  input  logic clr_req,
  input  logic err_clr,
  input  logic q_fb,
  input  logic qn_fb,
  output logic s,
  output logic r,
  output logic busy,
  output logic done,
  output logic err
);

  localparam int                 c_cnt_w        = cnt_width(PULSE_CYCLES, SETTLE_CYCLES);
  // The timer is loaded on the entry edge, so the first cycle of a phase
  // already shows N-1 and the phase ends in the cycle it reads zero.
  localparam logic [c_cnt_w-1:0] c_pulse_load   = c_cnt_w'(PULSE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_settle_load  = c_cnt_w'(SETTLE_CYCLES - 1);

  state_t             r_state;
  logic               w_start;
  logic               w_pulse_end;
  logic               w_settle_end;
  logic               w_load;
  logic [c_cnt_w-1:0] w_load_val;
  logic [c_cnt_w-1:0] w_cnt_unused;
  logic               w_zero;

`ifdef SR_LATCH_DRIVER_VERIFY_EN
  localparam int                   c_retry_w = retry_width(MAX_RETRY);
  cmd_t                 r_cmd;
  logic [c_retry_w-1:0] r_retry;
  logic                 w_match;
  logic                 w_can_retry;
  logic                 w_retry;
`else
  localparam int c_unused_max_retry = MAX_RETRY;
  logic          w_unused_fb;
  assign w_unused_fb = q_fb ^ qn_fb ^ err_clr;
`endif

  sr_pulse_timer #(
    .WIDTH (c_cnt_w)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (w_load_val),
    .value    (w_cnt_unused),
    .zero     (w_zero)
  );

  always_comb begin
    w_start      = (r_state == ST_IDLE) && (set_req || clr_req);
    w_pulse_end  = (r_state == ST_PULSE) && w_zero;
    w_settle_end = (r_state == ST_SETTLE) && w_zero;
`ifdef SR_LATCH_DRIVER_VERIFY_EN
    w_match      = (r_cmd == CMD_SET) ? (q_fb && !qn_fb) : (!q_fb && qn_fb);
    w_can_retry  = (int'(r_retry) < MAX_RETRY);
    w_retry      = (r_state == ST_CHECK) && !w_match && w_can_retry;
    w_load       = w_start || w_pulse_end || w_retry;
`else
    w_load       = w_start || w_pulse_end;
`endif
    w_load_val   = w_pulse_end ? c_settle_load : c_pulse_load;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      s       <= 1'b0;
      r       <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef SR_LATCH_DRIVER_VERIFY_EN
      r_cmd   <= CMD_SET;
      r_retry <= '0;
      err     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef SR_LATCH_DRIVER_VERIFY_EN
      // A failure later in this block overrides the clear.
      if (err_clr) err <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state <= ST_PULSE;
            busy    <= 1'b1;
            // clr_req has priority, so s and r can never both rise.
            s       <= !clr_req;
            r       <= clr_req;
`ifdef SR_LATCH_DRIVER_VERIFY_EN
            r_cmd   <= clr_req ? CMD_CLR : CMD_SET;
            r_retry <= '0;
`endif
          end
        end
        ST_PULSE: begin
          if (w_zero) begin
            r_state <= ST_SETTLE;
            s       <= 1'b0;
            r       <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (w_zero) begin
`ifdef SR_LATCH_DRIVER_VERIFY_EN
            r_state <= ST_CHECK;
`else
            r_state <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
`endif
          end
        end
`ifdef SR_LATCH_DRIVER_VERIFY_EN
        ST_CHECK: begin
          if (w_match) begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else if (w_can_retry) begin
            r_state <= ST_PULSE;
            r_retry <= r_retry + c_retry_w'(1);
            s       <= (r_cmd == CMD_SET);
            r       <= (r_cmd == CMD_CLR);
          end else begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            err     <= 1'b1;
          end
        end
`endif
        default: begin
          r_state <= ST_IDLE;
          s       <= 1'b0;
          r       <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifndef SR_LATCH_DRIVER_VERIFY_EN
  assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sr_latch_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sr_latch_driver
//  Purpose  : Self-checking bench for sr_latch_driver with a behavioural SR
//             latch on the readback path. Builds with or without
//             SR_LATCH_DRIVER_VERIFY_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sr_latch_driver;
  import sr_latch_driver_pkg::*;

  localparam int P  = 2;
  localparam int S  = 1;
  localparam int MR = 2;
`ifdef SR_LATCH_DRIVER_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic clk      = 1'b0;
  logic rst      = 1'b1;
  logic set_req  = 1'b0;
  logic clr_req  = 1'b0;
  logic err_clr  = 1'b0;
  logic force_q0 = 1'b0;
  logic q_lat    = 1'b0;
  logic q_fb, qn_fb, s, r, busy, done, err;

  int checks   = 0;
  int failures = 0;
  bit exp_err  = 1'b0;

  always #5 clk = ~clk;

  sr_latch_driver #(
    .PULSE_CYCLES  (P),
    .SETTLE_CYCLES (S),
    .MAX_RETRY     (MR)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .set_req (set_req),
    .clr_req (clr_req),
    .err_clr (err_clr),
    .q_fb    (q_fb),
    .qn_fb   (qn_fb),
    .s       (s),
    .r       (r),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  // Behavioural SR latch; force_q0 pins the q readback low.
  always @(s or r) begin
    if (s === 1'b1 && r !== 1'b1) q_lat = 1'b1;
    else if (r === 1'b1 && s !== 1'b1) q_lat = 1'b0;
  end
  assign q_fb  = force_q0 ? 1'b0 : q_lat;
  assign qn_fb = ~q_lat;

  // s and r must never be high together, in any cycle.
  always @(negedge clk) begin
    checks++;
    if ((s & r) !== 1'b0) begin
      failures++;
      $display("FAIL sr_exclusive s=%b r=%b at %0t", s, r, $time);
    end
  end

  // Entered and left at a falling edge; drives the request for the current
  // cycle (cycle 0) and checks every cycle up to and including done.
  task automatic run_cmd(input bit sr, input bit cr, input bit fq0,
                         input bit hold_set, input string tag);
    cmd_t cmd;
    bit   fail, act;
    int   att, len, t;
    logic [4:0] exp_v, got_v;
    cmd  = cr ? CMD_CLR : CMD_SET;
    fail = VERIFY && fq0 && (cmd == CMD_SET);
    att  = fail ? (1 + MR) : 1;
    len  = VERIFY ? (P + S + 1) : (P + S);
    t    = att * len;
    set_req  = sr;
    clr_req  = cr;
    force_q0 = fq0;
    for (int k = 1; k <= t + 1; k++) begin
      @(negedge clk);
      act = (k <= t) && (((k - 1) % len) < P);
      if (k == t + 1 && fail) exp_err = 1'b1;
      exp_v = {act && (cmd == CMD_SET), act && (cmd == CMD_CLR),
               k <= t, k == t + 1, exp_err};
      got_v = {s, r, busy, done, err};
      checks++;
      if (got_v !== exp_v) begin
        failures++;
        $display("FAIL %s cycle %0d {s,r,busy,done,err} got=%b exp=%b", tag, k, got_v, exp_v);
      end
      set_req = hold_set;
      clr_req = 1'b0;
    end
    checks++;
    if (q_lat !== (cmd == CMD_SET)) begin
      failures++;
      $display("FAIL %s latch_q got=%b exp=%b", tag, q_lat, (cmd == CMD_SET));
    end
    force_q0 = 1'b0;
  endtask

  task automatic idle(input int n);
    set_req = 1'b0;
    clr_req = 1'b0;
    repeat (n) begin
      @(negedge clk);
      checks++;
      if ({s, r, busy, done, err} !== {4'b0000, exp_err}) begin
        failures++;
        $display("FAIL idle {s,r,busy,done,err} got=%b exp=%b", {s, r, busy, done, err},
                 {4'b0000, exp_err});
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({s, r, busy, done, err} !== 5'b0) begin
        failures++;
        $display("FAIL reset_state got=%b exp=00000", {s, r, busy, done, err});
      end
    end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_set();
    run_cmd(1'b1, 1'b0, 1'b0, 1'b0, "set");
    idle(2);
  endtask

  task automatic test_both();
    run_cmd(1'b1, 1'b1, 1'b0, 1'b0, "both");
    idle(2);
  endtask

  task automatic test_hold_while_busy();
    run_cmd(1'b0, 1'b1, 1'b0, 1'b1, "hold_clr");
    run_cmd(1'b1, 1'b0, 1'b0, 1'b0, "hold_set");
    idle(2);
  endtask

  task automatic test_retry_err();
    run_cmd(1'b1, 1'b0, 1'b1, 1'b0, "retry");
    idle(1);
    err_clr = 1'b1;
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL err_clr got=%b exp=0", err);
    end
    exp_err = 1'b0;
    err_clr = 1'b0;
    idle(1);
  endtask

  task automatic test_reset_mid();
    clr_req = 1'b1;
    @(negedge clk);
    checks++;
    if ({r, busy} !== 2'b11) begin
      failures++;
      $display("FAIL rst_mid_pulse {r,busy} got=%b exp=11", {r, busy});
    end
    clr_req = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    checks++;
    if ({s, r, busy, done, err} !== 5'b0) begin
      failures++;
      $display("FAIL rst_mid_abort got=%b exp=00000", {s, r, busy, done, err});
    end
    rst     = 1'b0;
    exp_err = 1'b0;
    idle(6);
  endtask

  task automatic test_back_to_back();
    run_cmd(1'b1, 1'b0, 1'b0, 1'b0, "b2b0");
    run_cmd(1'b0, 1'b1, 1'b0, 1'b0, "b2b1");
    run_cmd(1'b1, 1'b0, 1'b0, 1'b0, "b2b2");
    run_cmd(1'b0, 1'b1, 1'b0, 1'b0, "b2b3");
    idle(2);
  endtask

  task automatic test_random();
    int  kind, gap;
    bit  fq0;
    for (int i = 0; i < 24; i++) begin
      kind = $urandom_range(0, 2);
      fq0  = ($urandom_range(0, 3) == 0);
      gap  = $urandom_range(0, 2);
      if (gap != 0) idle(gap);
      run_cmd(kind != 1, kind != 0, fq0, 1'b0, "rand");
    end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_set();
    test_both();
    test_hold_while_busy();
    test_retry_err();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
